// File: rtl/dat_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
// It also provides a registered fill level, an almost-full flag, a sticky overflow flag and a synchronous flush.
module dat_fifo #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       vld_i,
  input  logic [DAT_WIDTH-1:0]       dat_i,
  output logic                       rdy_o,
  output logic                       vld_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  input  logic                       rdy_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       afull_o,
  output logic                       ovf_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_TH);

  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Handshake outputs depend only on registered state, so rdy_i never reaches rdy_o.
  assign rdy_o   = (level_q != DEPTH_L);
  assign vld_o   = (level_q != '0);
  assign dat_o   = mem[rd_ptr_q];
  assign level_o = level_q;
  assign afull_o = afull_q;
  assign ovf_o   = ovf_q;

  always_comb begin
    push     = vld_i && rdy_o && !flush_i;
    pop      = vld_o && rdy_i && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (vld_i && !rdy_o) ovf_d = 1'b1;
    end
    afull_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset so it maps onto RAM; contents are only exposed while vld_o is high.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= dat_i;
  end

endmodule

// File: tb/tb_dat_fifo.sv
// Scoreboard bench for dat_fifo: accepted words are queued and then checked in order against dat_o.
// The fill level and all status flags are also compared against the queue model on every cycle.
module tb_dat_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, vld_i, rdy_i;
  logic [DW-1:0] dat_i, dat_o;
  logic          rdy_o, vld_o, afull_o, ovf_o;
  logic [LW-1:0] level_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] sb [$];
  bit            ovf_m = 1'b0;

  always #5 clk = ~clk;

  dat_fifo #(.DAT_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFT)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .vld_i   (vld_i),
    .dat_i   (dat_i),
    .rdy_o   (rdy_o),
    .vld_o   (vld_o),
    .dat_o   (dat_o),
    .rdy_i   (rdy_i),
    .level_o (level_o),
    .afull_o (afull_o),
    .ovf_o   (ovf_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable at the falling edge, so the model applies the upcoming edge's transaction here.
  always @(negedge clk) begin
    bit full;
    bit empty;
    if (rst_i) begin
      sb.delete();
      ovf_m = 1'b0;
    end else begin
      full  = (sb.size() == DEPTH);
      empty = (sb.size() == 0);
      check("level", 64'(level_o), 64'(sb.size()));
      check("vld_o", 64'(vld_o), 64'(!empty));
      check("rdy_o", 64'(rdy_o), 64'(!full));
      check("afull", 64'(afull_o), 64'(sb.size() >= AFT));
      check("ovf", 64'(ovf_o), 64'(ovf_m));
      if (!empty) check("dat_o", 64'(dat_o), 64'(sb[0]));
      if (flush_i) begin
        sb.delete();
        ovf_m = 1'b0;
      end else begin
        if (rdy_i && !empty) void'(sb.pop_front());
        if (vld_i) begin
          if (full) ovf_m = 1'b1;
          else      sb.push_back(dat_i);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    vld_i   = v;
    dat_i   = d;
    rdy_i   = r;
    flush_i = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; dat_i = '0;
    #1 rst_i = 1'b1;
    #1;
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_rdy", 64'(rdy_o), 64'd1);
    check("rst_vld", 64'(vld_o), 64'd0);
    check("rst_afull", 64'(afull_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Three words buffered while the consumer stalls, then drained in order.
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    check("fwft_head", 64'(dat_o), 64'h11);
    repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained_vld", 64'(vld_o), 64'd0);

    // Fill completely, then one extra push that must be dropped.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    check("full_level", 64'(level_o), 64'(DEPTH));
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    check("ovf_set", 64'(ovf_o), 64'd1);
    check("full_head", 64'(dat_o), 64'hA0);

    // A pop at full frees a slot, but the push in that same cycle is still refused.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_pop_level", 64'(level_o), 64'd15);
    check("full_pop_rdy", 64'(rdy_o), 64'd1);
    cyc(1'b1, 8'h56, 1'b0, 1'b0);
    check("refill_level", 64'(level_o), 64'(DEPTH));

    repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
    check("stream_level", 64'(level_o), 64'd8);

    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_flush_ovf", 64'(ovf_o), 64'd1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    check("flush_level", 64'(level_o), 64'd0);
    check("flush_ovf", 64'(ovf_o), 64'd0);
    check("flush_vld", 64'(vld_o), 64'd0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    check("post_flush_head", 64'(dat_o), 64'h77);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream: outputs must clear before the next clock edge.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_level", 64'(level_o), 64'd7);
    #2 rst_i = 1'b1;
    #1;
    check("arst_level", 64'(level_o), 64'd0);
    check("arst_vld", 64'(vld_o), 64'd0);
    check("arst_rdy", 64'(rdy_o), 64'd1);
    check("arst_afull", 64'(afull_o), 64'd0);
    check("arst_ovf", 64'(ovf_o), 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    check("post_rst_level", 64'(level_o), 64'd0);
    check("post_rst_rdy", 64'(rdy_o), 64'd1);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst_head", 64'(dat_o), 64'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
